tmon_master: RTL and testbench

TMON_MASTER -- requirements
Module: tmon_master

---
 rtl/tmon_pkg.sv | 36 +++
 rtl/tmon_cmd_fifo.sv | 56 +++++
 rtl/tmon_master.sv | 138 +++++++++++++
 tb/tb_tmon_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmon_pkg.sv
// Shared opcode/status encodings and command record for the temperature-monitor master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tmon_pkg;

    typedef enum logic [3:0] {
        OP_RESET         = 4'd0,
        OP_SET_FRQ       = 4'd1,
        OP_SET_HIGH_TEMP = 4'd2,
        OP_SET_LOW_TEMP  = 4'd3,
        OP_OUT_MAX       = 4'd4,
        OP_OUT_MIN       = 4'd5,
        OP_OUT_ADDR      = 4'd6,
        OP_OUT_AVG       = 4'd7
    } tmon_op_e;

    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } tmon_status_e;

    // Idle value driven on the slave opcode bus; any 8..15 opcode is a NOOP.
    localparam logic [3:0] TMON_NOOP = 4'b1000;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] opnd;
    } cmd_t;

    // Reads are opcodes 4..7.
    function automatic logic is_read_op(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/tmon_cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH, combinational head read, pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: full blocks push (ignored), empty blocks pop (ignored).
// Ports: clk, reset (async high), push/push_data, pop/pop_data, full, empty.
module tmon_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tmon_master.sv
// Temperature-monitor bus master: queues host commands, issues them to the slave, returns one response each.
// Latency: write/NOOP response 2 cycles after pop; read response 1 cycle after bus_valid, or error after TIMEOUT wait cycles.
// Backpressure: cmd_ready low when the FIFO is full (offered commands are dropped); issue waits for bus_ready.
// Ports: host side cmd_*/rsp_*, slave side bus_*, alarm/alarm_count status outputs.
module tmon_master
    import tmon_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_opnd,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [3:0] bus_op,
    output logic [7:0] bus_opnd,
    input  logic       bus_ready,
    input  logic       bus_valid,
    input  logic [7:0] bus_data,
    input  logic [1:0] bus_status,
    output logic [1:0] alarm,
    output logic [7:0] alarm_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_e;

    state_e        state;
    cmd_t          head;
    logic [3:0]    cur_op;
    logic [TW-1:0] timer;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          alarm_clear;

    assign cmd_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty && bus_ready;

    tmon_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (12)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_opnd}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_op    <= TMON_NOOP;
            timer     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            bus_op    <= TMON_NOOP;
            bus_opnd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        // Bus outputs are registered, so loading them here makes them
                        // visible for exactly the ISSUE cycle.
                        cur_op   <= head.op;
                        bus_op   <= head.op;
                        bus_opnd <= head.opnd;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_op   <= TMON_NOOP;
                    bus_opnd <= '0;
                    if (is_read_op(cur_op)) begin
                        timer <= '0;
                        state <= WAIT_RSP;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end
                end
                WAIT_RSP: begin
                    // Data arriving on the final timer cycle still counts as success.
                    if (bus_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= bus_data;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alarm_clear = (state == ISSUE) && (cur_op == 4'(OP_RESET));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm       <= 2'(ST_OK);
            alarm_count <= '0;
        end else begin
            alarm <= bus_status;
            // Clear takes priority over a same-cycle OK->alarm transition.
            if (alarm_clear) begin
                alarm_count <= '0;
            end else if (alarm == 2'(ST_OK) &&
                         (bus_status == 2'(ST_HIGH) || bus_status == 2'(ST_LOW)) &&
                         alarm_count != 8'hFF) begin
                alarm_count <= alarm_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tmon_master.sv
module tb_tmon_master;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic [7:0] cmd_opnd;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] bus_op;
    logic [7:0] bus_opnd;
    logic       bus_ready;
    logic       bus_valid;
    logic [7:0] bus_data;
    logic [1:0] bus_status;
    logic [1:0] alarm;
    logic [7:0] alarm_count;

    tmon_master #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_opnd    (cmd_opnd),
        .cmd_ready   (cmd_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .bus_op      (bus_op),
        .bus_opnd    (bus_opnd),
        .bus_ready   (bus_ready),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .bus_status  (bus_status),
        .alarm       (alarm),
        .alarm_count (alarm_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Commands are tracked as a queue; the in-flight command is described by its
    // age in cycles since the pop edge (age 1 = issue cycle, reads wait from age 2).
    typedef struct {
        logic [3:0] op;
        logic [7:0] opnd;
    } mcmd_t;

    mcmd_t      q[$];
    mcmd_t      cur;
    bit         busy    = 0;
    int         age     = 0;
    logic       m_rv    = 0;
    logic [7:0] m_rd    = 0;
    logic       m_re    = 0;
    logic [7:0] m_cnt   = 0;
    logic [1:0] m_alarm = 0;

    function automatic bit is_rd(input logic [3:0] op);
        return (op >= 4) && (op <= 7);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit do_push;
        bit do_pop;
        bit was_done;
        if (reset) begin
            q.delete();
            busy    = 0;
            age     = 0;
            m_rv    = 0;
            m_rd    = 0;
            m_re    = 0;
            m_cnt   = 0;
            m_alarm = 0;
        end else begin
            do_push  = cmd_valid && (q.size() < DEPTH);
            do_pop   = !busy && (q.size() > 0) && bus_ready;
            was_done = m_rv;
            if (busy && age == 1 && cur.op == 4'd0)
                m_cnt = 0;
            else if (m_alarm == 2'd0 && (bus_status == 2'd1 || bus_status == 2'd2) && m_cnt < 8'd255)
                m_cnt = m_cnt + 8'd1;
            m_alarm = bus_status;
            m_rv = 0;
            if (busy) begin
                if (was_done) begin
                    busy = 0;
                end else if (!is_rd(cur.op)) begin
                    if (age == 1) begin
                        m_rv = 1; m_rd = 0; m_re = 0;
                    end
                end else if (age >= 2) begin
                    if (bus_valid) begin
                        m_rv = 1; m_rd = bus_data; m_re = 0;
                    end else if (age - 2 == TIMEOUT - 1) begin
                        m_rv = 1; m_rd = 0; m_re = 1;
                    end
                end
                age++;
            end
            if (do_pop) begin
                cur  = q.pop_front();
                busy = 1;
                age  = 1;
            end
            if (do_push) q.push_back('{cmd_op, cmd_opnd});
        end
    end

    always @(negedge clk) begin : compare
        chk("cmd_ready",   32'(cmd_ready),   32'(q.size() < DEPTH));
        chk("rsp_valid",   32'(rsp_valid),   32'(m_rv));
        chk("rsp_data",    32'(rsp_data),    32'(m_rd));
        chk("rsp_err",     32'(rsp_err),     32'(m_re));
        chk("bus_op",      32'(bus_op),      (busy && age == 1) ? 32'(cur.op) : 32'd8);
        chk("bus_opnd",    32'(bus_opnd),    (busy && age == 1) ? 32'(cur.opnd) : 32'd0);
        chk("alarm",       32'(alarm),       32'(m_alarm));
        chk("alarm_count", 32'(alarm_count), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ops5 [5];
    logic [7:0] seen_opnd[$];

    initial begin
        int n;
        int nrsp;
        bit seen_rsp;
        bit seen_issue;

        reset = 1; cmd_valid = 0; cmd_op = 0; cmd_opnd = 0;
        bus_ready = 0; bus_valid = 0; bus_data = 0; bus_status = 0;
        step(); step();
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_bus_op",    32'(bus_op),    32'd8);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 0;
        bus_ready = 1;
        step();

        // SET_HIGH_TEMP 0x50
        cmd_valid = 1; cmd_op = 4'd2; cmd_opnd = 8'h50;
        step();
        cmd_valid = 0;
        step();
        chk("wr_issue_op",   32'(bus_op),   32'd2);
        chk("wr_issue_opnd", 32'(bus_opnd), 32'h50);
        chk("wr_issue_rv",   32'(rsp_valid), 32'd0);
        step();
        chk("wr_done_rv",   32'(rsp_valid), 32'd1);
        chk("wr_done_data", 32'(rsp_data),  32'd0);
        chk("wr_done_err",  32'(rsp_err),   32'd0);
        chk("wr_done_busop", 32'(bus_op),   32'd8);
        step();
        chk("wr_after_rv", 32'(rsp_valid), 32'd0);

        // OUT_MAX, slave answers 3 cycles after the issue cycle
        cmd_valid = 1; cmd_op = 4'd4; cmd_opnd = 8'h07;
        step();
        cmd_valid = 0;
        step();
        chk("rd_issue_op", 32'(bus_op), 32'd4);
        step(); step(); step();
        bus_valid = 1; bus_data = 8'h3C;
        step();
        bus_valid = 0; bus_data = 8'h00;
        chk("rd_rv",   32'(rsp_valid), 32'd1);
        chk("rd_data", 32'(rsp_data),  32'h3C);
        chk("rd_err",  32'(rsp_err),   32'd0);
        step();

        // OUT_AVG with no answer, followed by a queued SET_FRQ
        cmd_valid = 1; cmd_op = 4'd7; cmd_opnd = 8'h01;
        step();
        cmd_op = 4'd1; cmd_opnd = 8'h11;
        step();
        cmd_valid = 0;
        chk("to_issue_op", 32'(bus_op), 32'd7);
        n = 0;
        do begin
            step();
            n++;
        end while (!rsp_valid && n < 40);
        chk("to_latency", 32'(n), 32'(TIMEOUT + 1));
        chk("to_err",  32'(rsp_err),  32'd1);
        chk("to_data", 32'(rsp_data), 32'd0);
        step(); step();
        chk("to_next_op",   32'(bus_op),   32'd1);
        chk("to_next_opnd", 32'(bus_opnd), 32'h11);
        step();
        chk("to_next_rv",  32'(rsp_valid), 32'd1);
        chk("to_next_err", 32'(rsp_err),   32'd0);
        step();

        // Fill with bus_ready low: 4 accepted, 5th dropped, drained in order
        bus_ready = 0;
        ops5[0] = 4'd1; ops5[1] = 4'd3; ops5[2] = 4'd9; ops5[3] = 4'd2; ops5[4] = 4'd15;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1; cmd_op = ops5[i]; cmd_opnd = 8'hA0 + 8'(i);
            chk("fill_ready", 32'(cmd_ready), 32'(i < 4));
            step();
        end
        cmd_valid = 0;
        chk("fill_full", 32'(cmd_ready), 32'd0);
        bus_ready = 1;
        nrsp = 0;
        seen_opnd.delete();
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus_op != 4'd8) seen_opnd.push_back(bus_opnd);
            if (rsp_valid) nrsp++;
        end
        chk("drain_rsp_count",   32'(nrsp), 32'd4);
        chk("drain_issue_count", 32'(seen_opnd.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen_opnd.size(); i++)
            chk("drain_order", 32'(seen_opnd[i]), 32'hA0 + 32'(i));

        // Alarm transitions
        bus_status = 2'd1; step();
        bus_status = 2'd0; step();
        bus_status = 2'd2; step();
        chk("alarm_low", 32'(alarm), 32'd2);
        bus_status = 2'd0; step();
        chk("alarm_cnt2", 32'(alarm_count), 32'd2);
        repeat (300) begin
            bus_status = 2'd1; step();
            bus_status = 2'd0; step();
        end
        chk("alarm_sat", 32'(alarm_count), 32'd255);
        cmd_valid = 1; cmd_op = 4'd0; cmd_opnd = 8'h00;
        step();
        cmd_valid = 0;
        bus_status = 2'd1;
        step();
        chk("rst_issue_op",  32'(bus_op),      32'd0);
        chk("rst_issue_cnt", 32'(alarm_count), 32'd255);
        step();
        chk("rst_clear", 32'(alarm_count), 32'd0);
        bus_status = 2'd0;
        step(); step(); step();

        // Reset during WAIT_RSP with a second command queued
        cmd_valid = 1; cmd_op = 4'd5; cmd_opnd = 8'h22;
        step();
        cmd_valid = 0;
        step(); step();
        cmd_valid = 1; cmd_op = 4'd1; cmd_opnd = 8'h33;
        step();
        cmd_valid = 0;
        step();
        #2 reset = 1;
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid),   32'd0);
        chk("ar_rsp_data",  32'(rsp_data),    32'd0);
        chk("ar_rsp_err",   32'(rsp_err),     32'd0);
        chk("ar_bus_op",    32'(bus_op),      32'd8);
        chk("ar_bus_opnd",  32'(bus_opnd),    32'd0);
        chk("ar_alarm_cnt", 32'(alarm_count), 32'd0);
        chk("ar_cmd_ready", 32'(cmd_ready),   32'd1);
        step(); step();
        reset = 0;
        seen_rsp = 0; seen_issue = 0;
        for (int i = 0; i < 25; i++) begin
            bus_valid = 1'(i % 2); bus_data = 8'h5A;
            step();
            if (rsp_valid) seen_rsp = 1;
            if (bus_op != 4'd8) seen_issue = 1;
        end
        bus_valid = 0;
        chk("ar_no_rsp",   32'(seen_rsp),   32'd0);
        chk("ar_no_issue", 32'(seen_issue), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 2500; c++) begin
            cmd_valid = ($urandom_range(0, 99) < 40);
            cmd_op    = 4'($urandom_range(0, 15));
            cmd_opnd  = 8'($urandom);
            bus_ready = ($urandom_range(0, 99) < 70);
            bus_valid = ($urandom_range(0, 99) < 15);
            bus_data  = 8'($urandom);
            if ($urandom_range(0, 99) < 10) bus_status = 2'($urandom_range(0, 2));
            reset = (c >= 1200 && c < 1202);
            step();
        end
        cmd_valid = 0; bus_valid = 0; reset = 0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
